// File: rtl/occ_table_builder.sv
`default_nettype none
// ============================================================================
//  Module   : occ_table_builder
//  Purpose  : Builds the FM-index Occ table from a streamed BWT and serves
//             registered reads of packed per-base counts {T,G,C,A}.
//             IDLE --start--> BUILD --last / table full--> READY --start--> BUILD
//  Ports    : clk, rst_n (sync, active-low)
//             start                      - clear table, enter BUILD
//             sym_valid/sym_ready        - BWT symbol handshake
//             sym_base/sym_dollar/sym_last
//             ce_rom_Occ/addr_rom_Occ    - read request (READY only)
//             data/data_valid            - read result, 1-cycle latency
//             busy/done/len/ovf_err      - status
//  Revision : 1.0  initial release
// ============================================================================
module occ_table_builder #(
    parameter int DEPTH = 256,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               sym_valid,
    output logic               sym_ready,
    input  logic [1:0]         sym_base,
    input  logic               sym_dollar,
    input  logic               sym_last,
    input  logic               ce_rom_Occ,
    input  logic [7:0]         addr_rom_Occ,
    output logic [4*CNT_W-1:0] data,
    output logic               data_valid,
    output logic               busy,
    output logic               done,
    output logic [8:0]         len,
    output logic               ovf_err
);

    localparam int               c_AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0]       c_DEPTH   = 9'(DEPTH);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_BUILD = 2'd1;
    localparam logic [1:0] c_S_READY = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [8:0]         r_len;
    logic [8:0]         w_len_inc;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_cnt      [4];
    logic [CNT_W-1:0]   w_cnt_next [4];
    logic [3:0]         w_sat_hit;
    logic [4*CNT_W-1:0] w_entry;
    logic               w_hs;
    logic               w_enter_build;
    logic               w_len_full;
    logic               w_rd;
    logic [4*CNT_W-1:0] r_mem [0:DEPTH-1];
    logic [4*CNT_W-1:0] r_rd_word;
    logic               r_rd_oob;
    logic               r_data_valid;

    assign w_hs          = sym_valid & sym_ready;
    assign w_enter_build = start && (r_state != c_S_BUILD);
    assign w_len_inc     = r_len + 9'd1;
    assign w_len_full    = (w_len_inc == c_DEPTH);
    // start in READY takes precedence over a same-cycle read
    assign w_rd          = (r_state == c_S_READY) && ce_rom_Occ && !start;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE:  if (start) w_state_next = c_S_BUILD;
            c_S_BUILD: if (w_hs && (sym_last || w_len_full)) w_state_next = c_S_READY;
            c_S_READY: if (start) w_state_next = c_S_BUILD;
            default:   w_state_next = c_S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        sym_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            c_S_BUILD: begin
                busy      = 1'b1;
                sym_ready = (r_len < c_DEPTH);
            end
            c_S_READY: done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-base running counts. The entry written on a beat already
    // includes that beat's symbol (Occ is inclusive of row l).
    // ------------------------------------------------------------------
    for (genvar b = 0; b < 4; b++) begin : g_lane
        logic w_sel;
        assign w_sel         = w_hs && !sym_dollar && (sym_base == 2'(b));
        assign w_sat_hit[b]  = w_sel && (r_cnt[b] == c_CNT_MAX);
        assign w_cnt_next[b] = (w_sel && !w_sat_hit[b]) ? (r_cnt[b] + c_CNT_ONE) : r_cnt[b];
        assign w_entry[b*CNT_W +: CNT_W] = w_cnt_next[b];
    end

    always_ff @(posedge clk) begin
        if (!rst_n || w_enter_build) begin
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else if (w_hs) begin
            for (int i = 0; i < 4; i++) r_cnt[i] <= w_cnt_next[i];
        end
    end

    // Length and sticky overflow; ovf covers both a saturating increment
    // and running out of rows before sym_last arrives.
    always_ff @(posedge clk) begin
        if (!rst_n || w_enter_build) begin
            r_len <= '0;
            r_ovf <= 1'b0;
        end else if (w_hs) begin
            r_len <= w_len_inc;
            if ((|w_sat_hit) || (w_len_full && !sym_last)) r_ovf <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Table RAM: writes only in BUILD, reads only in READY.
    // Row index is bounded by len < DEPTH on every write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_hs) r_mem[r_len[c_AW-1:0]] <= w_entry;
    end

    // Raw RAM word is registered without reset; an out-of-range flag
    // (reset high) masks it so data reads 0 out of reset and for rows >= len.
    always_ff @(posedge clk) begin
        if (w_rd) r_rd_word <= r_mem[addr_rom_Occ[c_AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_oob     <= 1'b1;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_rd;
            if (w_rd) r_rd_oob <= ({1'b0, addr_rom_Occ} >= r_len);
        end
    end

    assign data       = r_rd_oob ? '0 : r_rd_word;
    assign data_valid = r_data_valid;
    assign len        = r_len;
    assign ovf_err    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_occ_table_builder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_occ_table_builder
//  Purpose  : Directed self-checking bench for occ_table_builder; one
//             instance at DEPTH=256 and one at DEPTH=4 for the full-table case.
//  Revision : 1.0  initial release
// ============================================================================
module tb_occ_table_builder;

    logic        clk = 1'b0;
    logic        rst_n;
    int          n_vec  = 0;
    int          n_fail = 0;

    // DEPTH=256 instance
    logic        start, sym_valid, sym_dollar, sym_last, ce;
    logic [1:0]  sym_base;
    logic [7:0]  addr;
    logic        sym_ready, data_valid, busy, done, ovf_err;
    logic [31:0] data;
    logic [8:0]  len;

    // DEPTH=4 instance
    logic        s4_start, s4_valid, s4_dollar, s4_last, s4_ce;
    logic [1:0]  s4_base;
    logic [7:0]  s4_addr;
    logic        s4_ready, s4_dv, s4_busy, s4_done, s4_ovf;
    logic [31:0] s4_data;
    logic [8:0]  s4_len;

    always #5 clk = ~clk;

    occ_table_builder #(.DEPTH(256), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_base(sym_base),
        .sym_dollar(sym_dollar), .sym_last(sym_last),
        .ce_rom_Occ(ce), .addr_rom_Occ(addr),
        .data(data), .data_valid(data_valid),
        .busy(busy), .done(done), .len(len), .ovf_err(ovf_err)
    );

    occ_table_builder #(.DEPTH(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(s4_start),
        .sym_valid(s4_valid), .sym_ready(s4_ready), .sym_base(s4_base),
        .sym_dollar(s4_dollar), .sym_last(s4_last),
        .ce_rom_Occ(s4_ce), .addr_rom_Occ(s4_addr),
        .data(s4_data), .data_valid(s4_dv),
        .busy(s4_busy), .done(s4_done), .len(s4_len), .ovf_err(s4_ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] b, input logic d, input logic l);
        sym_valid  = 1'b1;
        sym_base   = b;
        sym_dollar = d;
        sym_last   = l;
        step();
        sym_valid  = 1'b0;
        sym_dollar = 1'b0;
        sym_last   = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        ce   = 1'b1;
        addr = a;
        step();
        ce   = 1'b0;
    endtask

    task automatic rd4(input logic [7:0] a);
        s4_ce   = 1'b1;
        s4_addr = a;
        step();
        s4_ce   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 0; sym_valid = 0; sym_dollar = 0; sym_last = 0; ce = 0;
        sym_base = 2'd0; addr = 8'd0;
        s4_start = 0; s4_valid = 0; s4_dollar = 0; s4_last = 0; s4_ce = 0;
        s4_base = 2'd0; s4_addr = 8'd0;

        // ---- reset state ----
        step(); step();
        chk("rst_done",      32'(done),       32'd0);
        chk("rst_busy",      32'(busy),       32'd0);
        chk("rst_len",       32'(len),        32'd0);
        chk("rst_ready",     32'(sym_ready),  32'd0);
        chk("rst_dv",        32'(data_valid), 32'd0);
        chk("rst_data",      data,            32'd0);
        chk("rst_ovf",       32'(ovf_err),    32'd0);
        rst_n = 1'b1;
        step();

        // ---- start, read during BUILD is ignored ----
        start = 1'b1; step(); start = 1'b0;
        chk("build_busy",    32'(busy),       32'd1);
        chk("build_ready",   32'(sym_ready),  32'd1);
        rd(8'd0);
        chk("build_rd_dv",   32'(data_valid), 32'd0);
        chk("build_rd_data", data,            32'd0);

        // ---- stream A,C,$,G,T,A(last) ----
        send(2'd0, 1'b0, 1'b0);
        send(2'd1, 1'b0, 1'b0);
        send(2'd0, 1'b1, 1'b0);
        send(2'd2, 1'b0, 1'b0);
        send(2'd3, 1'b0, 1'b0);
        chk("pre_last_done", 32'(done),       32'd0);
        send(2'd0, 1'b0, 1'b1);
        chk("s1_done",       32'(done),       32'd1);
        chk("s1_busy",       32'(busy),       32'd0);
        chk("s1_len",        32'(len),        32'd6);
        chk("s1_ready",      32'(sym_ready),  32'd0);
        chk("s1_ovf",        32'(ovf_err),    32'd0);

        rd(8'd0); chk("row0", data, 32'h0000_0001); chk("row0_dv", 32'(data_valid), 32'd1);
        rd(8'd1); chk("row1", data, 32'h0000_0101);
        rd(8'd2); chk("row2", data, 32'h0000_0101);
        rd(8'd5); chk("row5", data, 32'h0101_0102); chk("row5_dv", 32'(data_valid), 32'd1);
        rd(8'd4); chk("row4", data, 32'h0101_0101);

        // ---- single request then idle: data held, valid drops ----
        rd(8'd3);
        chk("row3",          data,            32'h0001_0101);
        chk("row3_dv",       32'(data_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_dv",   32'(data_valid), 32'd0);
            chk("hold_data", data,            32'h0001_0101);
        end

        // ---- out-of-range address ----
        rd(8'd200);
        chk("oob_data",      data,            32'd0);
        chk("oob_dv",        32'(data_valid), 32'd1);
        rd(8'd6);
        chk("oob_len_data",  data,            32'd0);

        // ---- start and read in the same cycle: start wins ----
        start = 1'b1; ce = 1'b1; addr = 8'd0;
        step();
        start = 1'b0; ce = 1'b0;
        chk("sr_dv",         32'(data_valid), 32'd0);
        chk("sr_busy",       32'(busy),       32'd1);
        chk("sr_len",        32'(len),        32'd0);

        // ---- 256 A's, last on the final beat: saturation sets ovf ----
        for (int i = 0; i < 256; i++) begin
            if (i == 255) chk("sat_pre_ovf", 32'(ovf_err), 32'd0);
            send(2'd0, 1'b0, (i == 255));
        end
        chk("sat_done",      32'(done),       32'd1);
        chk("sat_len",       32'(len),        32'd256);
        chk("sat_ovf",       32'(ovf_err),    32'd1);
        rd(8'd0);   chk("sat_row0",   data, 32'h0000_0001);
        rd(8'd254); chk("sat_row254", data, 32'h0000_00FF);
        rd(8'd255); chk("sat_row255", data, 32'h0000_00FF);

        // ---- reset mid-BUILD, rebuild with a single G ----
        start = 1'b1; step(); start = 1'b0;
        send(2'd1, 1'b0, 1'b0);
        send(2'd3, 1'b0, 1'b0);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("mrst_done",     32'(done),       32'd0);
        chk("mrst_busy",     32'(busy),       32'd0);
        chk("mrst_len",      32'(len),        32'd0);
        start = 1'b1; step(); start = 1'b0;
        send(2'd2, 1'b0, 1'b1);
        chk("g_len",         32'(len),        32'd1);
        chk("g_ovf",         32'(ovf_err),    32'd0);
        chk("g_done",        32'(done),       32'd1);
        rd(8'd0);   chk("g_row0", data, 32'h0001_0000);

        // ---- DEPTH=4: 5 symbols, no last ----
        s4_start = 1'b1; step(); s4_start = 1'b0;
        s4_valid = 1'b1;
        s4_base = 2'd0; step();
        s4_base = 2'd1; step();
        s4_base = 2'd2; step();
        s4_base = 2'd3; step();
        chk("d4_done4",      32'(s4_done),    32'd1);
        chk("d4_ovf4",       32'(s4_ovf),     32'd1);
        s4_base = 2'd0; step();
        s4_valid = 1'b0;
        chk("d4_len",        32'(s4_len),     32'd4);
        chk("d4_ready",      32'(s4_ready),   32'd0);
        chk("d4_done",       32'(s4_done),    32'd1);
        rd4(8'd3); chk("d4_row3", s4_data, 32'h0101_0101);
        rd4(8'd0); chk("d4_row0", s4_data, 32'h0000_0001);
        rd4(8'd4); chk("d4_row4", s4_data, 32'd0);
        chk("d4_row4_dv",    32'(s4_dv),      32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
